// File: rtl/xpb_table_gen_pkg.sv
// Shared types and default sizing for the xpb table generator.
// Holds the FSM state encoding, default widths and limb-count helpers.
package xpb_gen_pkg;

    localparam int DEF_DATA_W = 1024;
    localparam int DEF_LIMB_W = 64;
    localparam int DEF_IDX_W  = 5;

    localparam int L    = DEF_DATA_W / DEF_LIMB_W;
    localparam int LC_W = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ZERO,
        ADD,
        WRITE,
        DONE
    } state_e;

    function automatic int lc_width(input int limbs);
        return (limbs > 1) ? $clog2(limbs) : 1;
    endfunction

endpackage

// File: rtl/xpb_table_gen_if.sv
// Control and table-write bundle between a configuration master and the xpb table generator.
// Pure wiring: no latency, no flow control beyond start/busy.
interface xpb_table_gen_if #(
    parameter int DATA_W = 1024,
    parameter int IDX_W  = 5
);
    logic              start;
    logic [DATA_W-1:0] base_in;
    logic [DATA_W-1:0] modulus_in;
    logic              busy;
    logic              done;
    logic              err;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output start, base_in, modulus_in,
        input  busy, done, err, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, base_in, modulus_in,
        output busy, done, err, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/xpb_limb_addsub.sv
// One limb of s = a + b + c followed by t = s - n - bw; carry and borrow chain through the parent's flops.
// Purely combinational, no backpressure.
module xpb_limb_addsub #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    input  logic [LIMB_W-1:0] n_i,
    input  logic              c_i,
    input  logic              bw_i,
    output logic [LIMB_W-1:0] s_o,
    output logic              c_o,
    output logic [LIMB_W-1:0] t_o,
    output logic              bw_o
);
    logic [LIMB_W:0] sum;
    logic [LIMB_W:0] dif;

    assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{LIMB_W{1'b0}}, c_i};
    // Top bit of the widened difference is the borrow out.
    assign dif  = {1'b0, sum[LIMB_W-1:0]} - {1'b0, n_i} - {{LIMB_W{1'b0}}, bw_i};

    assign s_o  = sum[LIMB_W-1:0];
    assign c_o  = sum[LIMB_W];
    assign t_o  = dif[LIMB_W-1:0];
    assign bw_o = dif[LIMB_W];
endmodule

// File: rtl/xpb_table_gen.sv
// Fills an xpb table with (j*B) mod N, one limb per cycle, one write every L+1 cycles; XPB_GEN_CHECK_EN adds a B<N range check.
// Latency: entry j at 1 + j*(L+1) cycles after start (+L with the check); start is ignored while busy.
module xpb_table_gen
    import xpb_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LIMB_W = DEF_LIMB_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic          clk,
    input  logic          reset,
    xpb_table_gen_if.slave bus
);
    localparam int NL    = DATA_W / LIMB_W;
    localparam int NLC_W = lc_width(NL);
    localparam logic [NLC_W-1:0] LC_LAST = NLC_W'(NL - 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  b_q, b_d, n_q, n_d, acc_q, acc_d;
    logic [DATA_W-1:0]  s_q, s_d, t_q, t_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NLC_W-1:0]   lc_q, lc_d;
    logic               c_q, c_d, bw_q, bw_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
    logic [IDX_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [LIMB_W-1:0]  s_limb, t_limb;
    logic               c_nxt, bw_nxt;
    logic [DATA_W-1:0]  r_sel;

    xpb_limb_addsub #(.LIMB_W(LIMB_W)) u_addsub (
        .a_i  (acc_q[LIMB_W-1:0]),
        .b_i  (b_q[LIMB_W-1:0]),
        .n_i  (n_q[LIMB_W-1:0]),
        .c_i  (c_q),
        .bw_i (bw_q),
        .s_o  (s_limb),
        .c_o  (c_nxt),
        .t_o  (t_limb),
        .bw_o (bw_nxt)
    );

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x);
        return (x >> LIMB_W) | (x << (DATA_W - LIMB_W));
    endfunction

    function automatic logic [DATA_W-1:0] shin(input logic [DATA_W-1:0] x,
                                               input logic [LIMB_W-1:0] limb);
        return (x >> LIMB_W) | (DATA_W'(limb) << (DATA_W - LIMB_W));
    endfunction

    // acc < N keeps s < 2N, so one conditional subtract fully reduces.
    assign r_sel = (c_q || !bw_q) ? t_q : s_q;

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        n_d       = n_q;
        acc_d     = acc_q;
        s_d       = s_q;
        t_d       = t_q;
        idx_d     = idx_q;
        lc_d      = lc_q;
        c_d       = c_q;
        bw_d      = bw_q;
        err_d     = err_q;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    b_d   = bus.base_in;
                    n_d   = bus.modulus_in;
                    acc_d = '0;
                    err_d = 1'b0;
                    c_d   = 1'b0;
                    bw_d  = 1'b0;
                    lc_d  = '0;
`ifdef XPB_GEN_CHECK_EN
                    state_d = CHECK;
`else
                    state_d = ZERO;
`endif
                end
            end
`ifdef XPB_GEN_CHECK_EN
            // acc is zero here, so the chain evaluates B - N; rotation restores b/n after L limbs.
            CHECK: begin
                b_d  = rotr(b_q);
                n_d  = rotr(n_q);
                c_d  = c_nxt;
                bw_d = bw_nxt;
                lc_d = lc_q + NLC_W'(1);
                if (lc_q == LC_LAST) begin
                    lc_d = '0;
                    if (bw_nxt) begin
                        state_d = ZERO;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
`endif
            ZERO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = '0;
                acc_d     = '0;
                idx_d     = IDX_W'(1);
                c_d       = 1'b0;
                bw_d      = 1'b0;
                lc_d      = '0;
                state_d   = ADD;
            end
            ADD: begin
                b_d   = rotr(b_q);
                n_d   = rotr(n_q);
                acc_d = acc_q >> LIMB_W;
                s_d   = shin(s_q, s_limb);
                t_d   = shin(t_q, t_limb);
                c_d   = c_nxt;
                bw_d  = bw_nxt;
                lc_d  = lc_q + NLC_W'(1);
                if (lc_q == LC_LAST) begin
                    lc_d    = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = r_sel;
                acc_d     = r_sel;
                c_d       = 1'b0;
                bw_d      = 1'b0;
                if (&idx_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            b_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            s_q       <= '0;
            t_q       <= '0;
            idx_q     <= '0;
            lc_q      <= '0;
            c_q       <= 1'b0;
            bw_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            s_q       <= s_d;
            t_q       <= t_d;
            idx_q     <= idx_d;
            lc_q      <= lc_d;
            c_q       <= c_d;
            bw_q      <= bw_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen at the default 1024/64/5 configuration.
module tb_xpb_table_gen;
    import xpb_gen_pkg::*;

    localparam int DW  = 1024;
    localparam int LW  = 64;
    localparam int IW  = 5;
    localparam int NLB = DW / LW;
    localparam int NE  = 1 << IW;
`ifdef XPB_GEN_CHECK_EN
    localparam int OFF = NLB;
`else
    localparam int OFF = 0;
`endif

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    xpb_table_gen_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    xpb_table_gen #(.DATA_W(DW), .LIMB_W(LW), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            exp_cyc[$];
    logic [DW-1:0] got_tab[NE];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input int j, input logic [DW-1:0] b, input logic [DW-1:0] n);
        logic [DW+IW-1:0] p;
        p = (DW+IW)'(b) * (DW+IW)'(j);
        return DW'(p % (DW+IW)'(n));
    endfunction

    function automatic logic [DW-1:0] rnd_wide();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Pops one expected write per observed strobe.
    always @(negedge clk) begin
        if (!reset && bus.wr_en) begin
            if (exp_addr.size() == 0) begin
                check_val("unexpected_wr", DW'(1), DW'(0));
            end else begin
                check_val("wr_addr", DW'(bus.wr_addr), DW'(exp_addr.pop_front()));
                check_val("wr_data", bus.wr_data, exp_data.pop_front());
                check_val("wr_cycle", DW'(cyc), DW'(exp_cyc.pop_front()));
                got_tab[bus.wr_addr] = bus.wr_data;
            end
        end
    end

    task automatic run_table(input logic [DW-1:0] b, input logic [DW-1:0] n,
                             input bit exp_err, input bit disturb, input int rst_at);
        int  t0;
        int  rel;
        int  done_at;
        bit  seen;
        seen           = 1'b0;
        bus.start      = 1'b1;
        bus.base_in    = b;
        bus.modulus_in = n;
        t0 = cyc + 1;
        if (!exp_err) begin
            for (int j = 0; j < NE; j++) begin
                exp_addr.push_back(IW'(j));
                exp_data.push_back(model(j, b, n));
                exp_cyc.push_back(t0 + 1 + OFF + j * (NLB + 1));
            end
            done_at = t0 + 1 + OFF + (NE - 1) * (NLB + 1) + 1;
        end else begin
            done_at = t0 + NLB + 1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_cycle0", DW'(bus.busy), DW'(0));
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (disturb && rel == 99) begin
                bus.start      = 1'b1;
                bus.base_in    = ~b;
                bus.modulus_in = rnd_wide();
            end
            if (disturb && rel == 100) bus.start = 1'b0;
            if (rel == 1) check_val("busy_cycle1", DW'(bus.busy), DW'(1));
            if (rel == rst_at) begin
                reset = 1'b1;
                #1;
                check_val("rst_busy", DW'(bus.busy), DW'(0));
                check_val("rst_done", DW'(bus.done), DW'(0));
                check_val("rst_err", DW'(bus.err), DW'(0));
                check_val("rst_wr_en", DW'(bus.wr_en), DW'(0));
                check_val("rst_wr_addr", DW'(bus.wr_addr), DW'(0));
                check_val("rst_wr_data", bus.wr_data, DW'(0));
                check_val("rst_pending", DW'(exp_addr.size()), DW'(NE - 7));
                exp_addr.delete();
                exp_data.delete();
                exp_cyc.delete();
                repeat (2) @(negedge clk);
                reset = 1'b0;
                repeat (30) @(negedge clk);
                check_val("post_rst_busy", DW'(bus.busy), DW'(0));
                return;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_val("done_timeout", DW'(0), DW'(1));
        end else begin
            check_val("done_cycle", DW'(cyc), DW'(done_at));
            check_val("busy_at_done", DW'(bus.busy), DW'(1));
            check_val("err", DW'(bus.err), DW'(exp_err));
            check_val("sb_empty", DW'(exp_addr.size()), DW'(0));
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_val("idle_busy", DW'(bus.busy), DW'(0));
        check_val("idle_done", DW'(bus.done), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] nv;
        logic [DW-1:0] bv;
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.base_in    = '0;
        bus.modulus_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("reset_busy", DW'(bus.busy), DW'(0));
        check_val("reset_done", DW'(bus.done), DW'(0));
        check_val("reset_err", DW'(bus.err), DW'(0));
        check_val("reset_wr_en", DW'(bus.wr_en), DW'(0));
        check_val("reset_wr_data", bus.wr_data, DW'(0));

        // Small modulus: 0x00, 0x80, 0x05, 0x85, 0x0A ...
        run_table(DW'(8'h80), DW'(8'hFB), 1'b0, 1'b0, -1);
        check_val("small_e2", got_tab[2], DW'(8'h05));
        check_val("small_e4", got_tab[4], DW'(8'h0A));
        // Back-to-back: start driven in the cycle after done.
        run_table(DW'(8'hFE), DW'(8'hFF), 1'b0, 1'b0, -1);
        check_val("ff_e2", got_tab[2], DW'(8'hFD));
        check_val("ff_e3", got_tab[3], DW'(8'hFC));
        idle_check();

        // Full-width all-ones modulus forces the carry-out path.
        nv = '1;
        run_table(nv - DW'(1), nv, 1'b0, 1'b0, -1);
        idle_check();

        // B just above N/16 makes entry 16 wrap below entry 15.
        nv = rnd_wide();
        nv[DW-1] = 1'b1;
        nv[0] = 1'b1;
        bv = (nv >> 4) + DW'(1);
        run_table(bv, nv, 1'b0, 1'b0, -1);
        check_val("wrap16", DW'(got_tab[16] < got_tab[15]), DW'(1));
        idle_check();

        nv = rnd_wide();
        nv[DW-1] = 1'b1;
        bv = rnd_wide() % nv;
        run_table(bv, nv, 1'b0, 1'b1, -1);
        idle_check();

        nv = rnd_wide();
        nv[DW-2] = 1'b1;
        bv = rnd_wide() % nv;
        run_table(bv, nv, 1'b0, 1'b0, 110 + OFF);
        run_table(bv, nv, 1'b0, 1'b0, -1);
        idle_check();

`ifdef XPB_GEN_CHECK_EN
        run_table(nv, nv, 1'b1, 1'b0, -1);
        idle_check();
        check_val("err_held", DW'(bus.err), DW'(1));
        run_table(nv - DW'(1), nv, 1'b0, 1'b0, -1);
        check_val("chk_e1", got_tab[1], nv - DW'(1));
        idle_check();
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
